// File: rtl/seg_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_pkg
// Brief    : Shared constants, scan-phase enum and anode mask helper for
//            the multiplexed 7-segment display scanner.
// Revision : 1.0
// ============================================================================
package seg_scan_pkg;

    localparam int               SEG_W      = 7;
    localparam logic [SEG_W-1:0] SEG_OFF    = 7'h7F;
    localparam int               MAX_DIGITS = 16;

    typedef enum logic [0:0] {
        ST_DEAD = 1'b0,
        ST_ON   = 1'b1
    } scan_state_t;

    // Digit 0 sits on the most significant anode, so digit idx clears bit n-1-idx.
    function automatic logic [MAX_DIGITS-1:0] anode_onecold(input int unsigned n_digits,
                                                           input int unsigned idx);
        logic [MAX_DIGITS-1:0] mask;
        mask = '1;
        mask[4'(n_digits - 1 - idx)] = 1'b0;
        return mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_next_idx.sv
`default_nettype none
// ============================================================================
// Module   : seg_next_idx
// Brief    : Rotating-priority search for the next enabled digit after idx,
//            with a flag telling whether the search wrapped past the top.
// Revision : 1.0
// ============================================================================
module seg_next_idx #(
    parameter int N_DIGITS = 8,
    parameter int IW       = $clog2(N_DIGITS)
) (
    input  logic [IW-1:0]       idx,
    input  logic [N_DIGITS-1:0] digit_en,
    output logic [IW-1:0]       next_idx,
    output logic                wrap
);

    always_comb begin
        int best_i;
        int best_d;
        int d;
        best_i   = 0;
        best_d   = N_DIGITS + 1;
        d        = 0;
        next_idx = idx;
        wrap     = 1'b0;
        // Distance from idx going upward; the current digit itself ranks last.
        for (int i = 0; i < N_DIGITS; i++) begin
            d = i - int'(idx);
            if (d <= 0) d = d + N_DIGITS;
            if (digit_en[i] && (d < best_d)) begin
                best_d = d;
                best_i = i;
            end
        end
        if (best_d <= N_DIGITS) begin
            next_idx = IW'(best_i);
            wrap     = (best_i <= int'(idx));
        end else begin
            wrap     = (int'(idx) == N_DIGITS - 1);
            next_idx = wrap ? '0 : idx + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/seg_scan_mux.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_mux
// Brief    : N-digit 7-segment scanner with per-digit enable/skip, dead time,
//            global blank and frame strobe. Define SEG_SCAN_DIMMING_EN to
//            enable PWM dimming of the anodes through the brightness port.
// Revision : 1.0
// ============================================================================
module seg_scan_mux
    import seg_scan_pkg::*;
#(
    parameter int N_DIGITS    = 8,
    parameter int DIGIT_TICKS = 131072,
    parameter int DEAD_TICKS  = 1024
) (
    input  logic                          clock_100Mhz,
    input  logic                          reset,
    input  logic [7*N_DIGITS-1:0]         seg_data,
    input  logic [N_DIGITS-1:0]           dp_data,
    input  logic [N_DIGITS-1:0]           digit_en,
    input  logic                          blank,
    input  logic [3:0]                    brightness,
    output logic [N_DIGITS-1:0]           Anode_Activate,
    output logic [6:0]                    LED_out,
    output logic                          dp_out,
    output logic [$clog2(N_DIGITS)-1:0]   scan_idx,
    output logic                          frame_tick
);

    localparam int IW = $clog2(N_DIGITS);
    localparam int TW = $clog2(DIGIT_TICKS);

    if (DEAD_TICKS >= DIGIT_TICKS) begin : g_bad_dead
        $error("seg_scan_mux: DEAD_TICKS must be strictly less than DIGIT_TICKS");
    end
    if ((N_DIGITS < 2) || (N_DIGITS > MAX_DIGITS)) begin : g_bad_digits
        $error("seg_scan_mux: N_DIGITS must be in 2..16");
    end

    logic [TW-1:0]         tick_cnt;
    logic [TW-1:0]         tick_nxt;
    logic                  tick_last;
    scan_state_t           state;
    scan_state_t           state_nxt;
    logic [IW-1:0]         adv_idx;
    logic                  adv_wrap;
    logic [IW-1:0]         scan_nxt;
    logic [SEG_W-1:0]      seg_cap;
    logic [SEG_W-1:0]      seg_sel;
    logic [SEG_W-1:0]      led_nxt;
    logic                  dp_cap;
    logic                  dp_sel;
    logic                  dp_nxt;
    logic                  en_sel;
    logic                  capture;
    logic                  lit;
    logic                  dim_ok;
    logic [N_DIGITS-1:0]   anode_nxt;
    logic [MAX_DIGITS-1:0] onecold_full;
    logic                  unused_onecold;

    assign unused_onecold = ^onecold_full;

    assign tick_last = (tick_cnt == TW'(DIGIT_TICKS - 1));
    assign tick_nxt  = tick_last ? '0 : tick_cnt + 1'b1;
    // Every output is computed from the values the counters take after this edge.
    assign scan_nxt  = tick_last ? adv_idx : scan_idx;

    seg_next_idx #(
        .N_DIGITS (N_DIGITS),
        .IW       (IW)
    ) u_next_idx (
        .idx      (scan_idx),
        .digit_en (digit_en),
        .next_idx (adv_idx),
        .wrap     (adv_wrap)
    );

`ifdef SEG_SCAN_DIMMING_EN
    assign dim_ok = (4'(32'(tick_nxt)) <= brightness);
`else
    logic unused_brightness;
    assign unused_brightness = ^brightness;
    assign dim_ok            = 1'b1;
`endif

    always_ff @(posedge clock_100Mhz or negedge reset) begin
        if (!reset) begin
            state    <= ST_DEAD;
            tick_cnt <= '0;
        end else begin
            state    <= state_nxt;
            tick_cnt <= tick_nxt;
        end
    end

    always_comb begin
        state_nxt = (tick_nxt >= TW'(DEAD_TICKS)) ? ST_ON : ST_DEAD;
    end

    always_comb begin
        seg_sel      = SEG_OFF;
        dp_sel       = 1'b1;
        en_sel       = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (scan_nxt == IW'(i)) begin
                seg_sel = seg_data[SEG_W*i +: SEG_W];
                dp_sel  = dp_data[i];
                en_sel  = digit_en[i];
            end
        end
        capture      = (state_nxt == ST_ON) && ((state == ST_DEAD) || tick_last);
        lit          = (state_nxt == ST_ON) && en_sel;
        led_nxt      = lit ? (capture ? seg_sel : seg_cap) : SEG_OFF;
        dp_nxt       = lit ? (capture ? dp_sel : dp_cap) : 1'b1;
        onecold_full = anode_onecold(N_DIGITS, 32'(scan_nxt));
        anode_nxt    = (lit && !blank && dim_ok) ? onecold_full[N_DIGITS-1:0] : '1;
    end

    always_ff @(posedge clock_100Mhz or negedge reset) begin
        if (!reset) begin
            Anode_Activate <= '1;
            LED_out        <= SEG_OFF;
            dp_out         <= 1'b1;
            scan_idx       <= '0;
            frame_tick     <= 1'b0;
            seg_cap        <= SEG_OFF;
            dp_cap         <= 1'b1;
        end else begin
            Anode_Activate <= anode_nxt;
            LED_out        <= led_nxt;
            dp_out         <= dp_nxt;
            scan_idx       <= scan_nxt;
            frame_tick     <= tick_last & adv_wrap;
            if (capture) begin
                seg_cap <= seg_sel;
                dp_cap  <= dp_sel;
            end
        end
    end

endmodule
`default_nettype wire
